lm_sm_sequencer: RTL

//   Multi-cycle sequencer for LM (0110) / SM (0111) in the memory-access stage.

---
 rtl/lm_sm_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/lm_sm_sequencer.sv
// LM/SM multi-cycle sequencer for the memory-access stage.
// Walks the register mask lowest-first, one access per cycle.
module lm_sm_sequencer #(
    parameter int ADDR_W = 16,
    parameter int MASK_W = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              is_sm,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [MASK_W-1:0] reg_mask,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic              rf_write,
    output logic [IDX_W-1:0]  reg_idx,
    output logic              stall_req,
    output logic              busy,
    output logic              last,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                sm_q, sm_d;
    logic [IDX_W-1:0]    low_idx;
    logic                one_left;
    logic                take;

    // Lowest set bit wins: scan from the top so the last hit is the lowest.
    always_comb begin
        low_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = IDX_W'(i);
        end
    end

    assign one_left = (mask_q & (mask_q - MASK_W'(1))) == '0;
    assign take     = start && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            sm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            sm_q    <= sm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        sm_d      = sm_q;
        mem_addr  = '0;
        mem_write = 1'b0;
        rf_write  = 1'b0;
        reg_idx   = '0;
        stall_req = 1'b0;
        busy      = 1'b0;
        last      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (take) begin
                    if (reg_mask != '0) begin
                        state_d   = S_RUN;
                        mask_d    = reg_mask;
                        addr_d    = base_addr;
                        sm_d      = is_sm;
                        stall_req = reset_n;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                mem_addr  = addr_q;
                reg_idx   = low_idx;
                mem_write = sm_q && !abort;
                rf_write  = !sm_q && !abort;
                last      = one_left;
                stall_req = !one_left;
                mask_d    = mask_q & (mask_q - MASK_W'(1));
                addr_d    = addr_q + ADDR_W'(1);
                if (abort) begin
                    state_d = S_IDLE;
                    mask_d  = '0;
                end else if (one_left) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
